// File: rtl/pcie_seq_pkg.sv
// Shared types and default limits for the PCIe lane bring-up sequencer.
package pcie_seq_pkg;

    localparam int unsigned PCIE_NUM_LANES      = 8;
    localparam int unsigned DEF_RST_HOLD_CYCLES = 256;
    localparam int unsigned DEF_LINK_TIMEOUT    = 1048576;
    localparam int unsigned DEF_MAX_RETRY       = 3;

    typedef enum logic [2:0] {
        RESET_HOLD,
        WAIT_LOCK,
        TRAIN,
        UP,
        FAILED
    } seq_state_t;

endpackage

// File: rtl/pcie_seq_sync.sv
// Parameterised-width 2-flop synchronizer, asynchronous active-low reset to 0.
module pcie_seq_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pcie_lane_sequencer.sv
// PHY reset / PLL lock / link training sequencer with bounded retries.
// Define PCIE_SEQ_SYNC_EN to pass clk_locked, link_up and lane_active through 2-flop synchronizers.
module pcie_lane_sequencer
    import pcie_seq_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
    parameter int unsigned LINK_TIMEOUT    = DEF_LINK_TIMEOUT,
    parameter int unsigned MAX_RETRY       = DEF_MAX_RETRY
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      clk_locked,
    input  logic                      link_up,
    input  logic [PCIE_NUM_LANES-1:0] lane_active,
    input  logic [PCIE_NUM_LANES-1:0] lane_mask,
    input  logic                      restart,
    output logic                      phy_rst_n,
    output logic [PCIE_NUM_LANES-1:0] lane_en,
    output logic                      ready,
    output logic                      fail,
    output logic [1:0]                retry_cnt
);

    localparam int unsigned TMR_MAX = (RST_HOLD_CYCLES > LINK_TIMEOUT) ? RST_HOLD_CYCLES : LINK_TIMEOUT;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] HOLD_LOAD  = TMR_W'(RST_HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] TRAIN_LOAD = TMR_W'(LINK_TIMEOUT - 1);
    localparam logic [1:0]       RETRY_MAX  = 2'(MAX_RETRY);

    logic                      locked_s;
    logic                      link_up_s;
    logic [PCIE_NUM_LANES-1:0] lane_active_s;

`ifdef PCIE_SEQ_SYNC_EN
    pcie_seq_sync #(.WIDTH(PCIE_NUM_LANES + 2)) u_sync (
        .CLK   (CLK),
        .RST_N (RST_N),
        .d     ({clk_locked, link_up, lane_active}),
        .q     ({locked_s, link_up_s, lane_active_s})
    );
`else
    assign locked_s      = clk_locked;
    assign link_up_s     = link_up;
    assign lane_active_s = lane_active;
`endif

    seq_state_t                state;
    logic [TMR_W-1:0]          tmr;
    logic [PCIE_NUM_LANES-1:0] mask_q;
    logic [PCIE_NUM_LANES-1:0] next_mask;
    logic                      lanes_ok;

    // An empty mask means "train every lane".
    assign next_mask = (lane_mask == '0) ? '1 : lane_mask;
    assign lanes_ok  = (lane_active_s & mask_q) == mask_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= RESET_HOLD;
            tmr       <= HOLD_LOAD;
            mask_q    <= '0;
            phy_rst_n <= 1'b0;
            lane_en   <= '0;
            ready     <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= '0;
        end else if (restart) begin
            state     <= RESET_HOLD;
            tmr       <= HOLD_LOAD;
            phy_rst_n <= 1'b0;
            lane_en   <= '0;
            ready     <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= '0;
        end else begin
            case (state)
                RESET_HOLD: begin
                    if (tmr == '0) state <= WAIT_LOCK;
                    else           tmr   <= tmr - 1'b1;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state     <= TRAIN;
                        mask_q    <= next_mask;
                        lane_en   <= next_mask;
                        phy_rst_n <= 1'b1;
                        tmr       <= TRAIN_LOAD;
                    end
                end
                TRAIN: begin
                    // Success is checked first so it wins over a coincident timeout.
                    if (link_up_s && lanes_ok) begin
                        state     <= UP;
                        ready     <= 1'b1;
                        retry_cnt <= '0;
                    end else if (!locked_s) begin
                        state     <= RESET_HOLD;
                        tmr       <= HOLD_LOAD;
                        phy_rst_n <= 1'b0;
                        lane_en   <= '0;
                    end else if (tmr == '0) begin
                        phy_rst_n <= 1'b0;
                        lane_en   <= '0;
                        if (retry_cnt == RETRY_MAX) begin
                            state <= FAILED;
                            fail  <= 1'b1;
                        end else begin
                            state     <= RESET_HOLD;
                            tmr       <= HOLD_LOAD;
                            retry_cnt <= retry_cnt + 2'd1;
                        end
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                UP: begin
                    if (!link_up_s || !locked_s || !lanes_ok) begin
                        state     <= RESET_HOLD;
                        tmr       <= HOLD_LOAD;
                        phy_rst_n <= 1'b0;
                        lane_en   <= '0;
                        ready     <= 1'b0;
                        retry_cnt <= '0;
                    end
                end
                FAILED: ;
                default: begin
                    state     <= RESET_HOLD;
                    tmr       <= HOLD_LOAD;
                    phy_rst_n <= 1'b0;
                    lane_en   <= '0;
                    ready     <= 1'b0;
                    fail      <= 1'b0;
                    retry_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/pcie_lane_sequencer.md
# pcie_lane_sequencer

Bring-up and recovery sequencer for the 8-lane PCI Express pin interface on the BlueNoC physical device. It holds the PHY in reset for a fixed interval and waits for the reference PLL to lock. It then enables the configured lanes and waits for link-up with every configured lane active. Training attempts are retried up to a bound, a lost link is re-trained, and the block reports `ready`/`fail` to the platform layer.

## Interface
- `RST_HOLD_CYCLES`, 256: cycles the PHY reset is held in each reset phase (≥2).
- `LINK_TIMEOUT`, 1048576: cycles allowed in TRAIN per attempt (≥2).
- `MAX_RETRY`, 3: retries after the first attempt before FAILED (1..3).
- `CLK`  in  1  sole clock; all flops rising-edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `clk_locked`  in  1  reference PLL lock.
- `link_up`  in  1  PHY link-up status.
- `lane_active`  in  8  per-lane activity from the pin interface.
- `lane_mask`  in  8  lanes to train; latched on TRAIN entry.
- `restart`  in  1  single-cycle pulse; forces a full re-sequence.
- `phy_rst_n`  out  1  PHY reset, active-low.
- `lane_en`  out  8  per-lane enable.
- `ready`  out  1  link up and all masked lanes active.
- `fail`  out  1  retries exhausted.
- `retry_cnt`  out  2  retries consumed in the current bring-up.

## Operation
- States: RESET_HOLD, WAIT_LOCK, TRAIN, UP, FAILED. A single down-counter `tmr` is used, sized to `$clog2` of the larger limit.
- After reset the block is in RESET_HOLD with `tmr=RST_HOLD_CYCLES-1`. All outputs are 0, so `phy_rst_n=0` and `lane_en=8'h00`.
- **RESET_HOLD:** `tmr` decrements each cycle. When `tmr==0`, the block moves to WAIT_LOCK.
- **WAIT_LOCK:** the block waits indefinitely for `clk_locked=1`, then moves to TRAIN. On TRAIN entry:
  - `mask_q<=lane_mask`. A `lane_mask` of 0 is latched as 8'hFF.
  - `tmr<=LINK_TIMEOUT-1`.
- **TRAIN:** `phy_rst_n=1` and `lane_en=mask_q`.
  - If `link_up && (lane_active & mask_q)==mask_q`, go to UP.
  - If `clk_locked` drops, go to RESET_HOLD without consuming a retry.
  - If `tmr==0` and `retry_cnt==MAX_RETRY`, go to FAILED.
  - If `tmr==0` otherwise, `retry_cnt` increments and the block goes to RESET_HOLD.
  - If success and timeout occur in the same cycle, success wins.
- **UP:** `ready=1` and `retry_cnt` clears on entry. If `link_up`, `clk_locked`, or any masked lane drops, the block goes to RESET_HOLD with `retry_cnt=0`.
- **FAILED:** `fail=1`, `phy_rst_n=0`, `lane_en=0`. The block stays here until `restart`.
- **restart:** in any state, it forces RESET_HOLD with `retry_cnt=0` and `tmr` reloaded. It overrides every other transition in that cycle.
- Whenever RESET_HOLD is entered, `tmr` reloads to `RST_HOLD_CYCLES-1`.
- Changes to `lane_mask` outside TRAIN entry are ignored.

## Timing
- All outputs are flops written on the same edge that the state register updates. Outputs never glitch.
- Without sync, inputs are sampled directly: a condition true before edge N takes effect at edge N.
- RESET_HOLD lasts exactly `RST_HOLD_CYCLES` cycles. `phy_rst_n` rises on the edge after `clk_locked` is seen in WAIT_LOCK.
- A TRAIN attempt lasts exactly `LINK_TIMEOUT` cycles when it times out.
- The effect of `RST_N` assertion on outputs is immediate and asynchronous. Release must be synchronized externally to `CLK`.

## Configuration
- `PCIE_SEQ_SYNC_EN` defined: `clk_locked`, `link_up` and `lane_active` each pass through a 2-flop synchronizer. Every input-driven transition occurs 2 cycles later than stated above. The synchronizer flops reset to 0.
- Not defined: inputs are used directly, for when they are already in the `CLK` domain.

## Structure
- Package `pcie_seq_pkg` holds:
  - the state enum;
  - `PCIE_NUM_LANES=8`;
  - the default limits.
- Sub-module `pcie_seq_sync`: a parameterised-width 2-flop synchronizer with asynchronous active-low reset. It is instantiated only under `PCIE_SEQ_SYNC_EN`.

## Test plan
- Bench parameters: `RST_HOLD_CYCLES=4`, `LINK_TIMEOUT=16`, `MAX_RETRY=2`, macro off.
- **Nominal bring-up:** with `clk_locked=1`, `lane_mask=8'h0F`, `lane_active=8'h0F`, `link_up=1` from cycle 0 → `phy_rst_n` rises at edge 5, `lane_en=8'h0F`, and `ready=1` at edge 6.
- **Retry to failure:** `link_up` held at 0 → `retry_cnt` goes 1 then 2, and `fail=1` after 3×(4+1+16) cycles. `phy_rst_n=0` and `lane_en=0` in FAILED.
- **Partial lanes:** `lane_mask=8'hFF`, `lane_active=8'h7F`, `link_up=1` → no `ready`. The block times out and `retry_cnt=1`.
- **Link loss and restart:** in UP, drop `lane_active[0]` for one cycle → `ready=0` and RESET_HOLD on the next edge with `retry_cnt=0`. A `restart` pulse in FAILED → RESET_HOLD and `fail=0`.
- **Lock and sync:** a `clk_locked` drop in TRAIN → RESET_HOLD with `retry_cnt` unchanged. Repeat the nominal case with `PCIE_SEQ_SYNC_EN` defined → every input-driven transition is 2 cycles later.
